// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: converts a 16-bit unsigned value to five packed BCD digits,
// one double-dabble iteration per clock, with a start/busy/done handshake.
`default_nettype none

module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] din,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [35:0] work, work_n;   // {digits[19:0], bin[15:0]}
  logic [4:0]  cnt, cnt_n;
  logic [19:0] bcd_n;
  logic        done_n;

  logic [19:0] adj;
  logic [35:0] shifted;

  // Add-3 correction on every digit in parallel, ahead of the shift.
  generate
    for (genvar g = 0; g < 5; g++) begin : g_adj
      assign adj[4*g +: 4] = (work[16 + 4*g +: 4] >= 4'd5) ?
                             (work[16 + 4*g +: 4] + 4'd3) :
                              work[16 + 4*g +: 4];
    end
  endgenerate

  assign shifted = {adj[18:0], work[15:0], 1'b0};

  always_comb begin
    state_n = state;
    work_n  = work;
    cnt_n   = cnt;
    bcd_n   = bcd;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          work_n  = {20'h00000, din};
          cnt_n   = 5'd16;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        work_n = shifted;
        cnt_n  = cnt - 5'd1;
        // Last iteration: the freshly shifted digits are the result.
        if (cnt == 5'd1) begin
          bcd_n   = shifted[35:16];
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      work  <= 36'd0;
      cnt   <= 5'd0;
      bcd   <= 20'h00000;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      work  <= work_n;
      cnt   <= cnt_n;
      bcd   <= bcd_n;
      done  <= done_n;
      busy  <= (state_n == SHIFT);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
`default_nettype none

module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] din = 16'd0;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int errors = 0;
  int checks = 0;

  bin2bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  // Pulses start for one edge and observes the conversion at each negedge;
  // j counts negedges after the accepting edge k.
  task automatic convert(input logic [15:0] val, output logic [19:0] res,
                         output int busy_cnt, output int dcnt, output int dpos);
    res = 20'hxxxxx; busy_cnt = 0; dcnt = 0; dpos = -1;
    din = val; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (busy) busy_cnt++;
      if (done) begin
        dcnt++;
        if (dpos < 0) dpos = j;
        res = bcd;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h00000) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b bcd=%h required 0 0 00000", busy, done, bcd);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h00000) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b bcd=%h required 0 0 00000", busy, done, bcd);
    end
  endtask

  task automatic test_zero();
    logic [19:0] r; int bc, dc, dp;
    convert(16'd0, r, bc, dc, dp);
    checks++;
    if (bc !== 16) begin errors++; $display("FAIL zero_busy_cycles: got %0d required 16", bc); end
    checks++;
    if (dc !== 1 || dp !== 16) begin
      errors++; $display("FAIL zero_done: count=%0d pos=%0d required 1 at 16", dc, dp);
    end
    checks++;
    if (r !== 20'h00000) begin errors++; $display("FAIL zero_bcd: got %h required 00000", r); end
  endtask

  task automatic test_values();
    logic [15:0] vin [4]  = '{16'd65535, 16'd12345, 16'd9, 16'd10};
    logic [19:0] vexp [4] = '{20'h65535, 20'h12345, 20'h00009, 20'h00010};
    logic [19:0] r; int bc, dc, dp;
    for (int i = 0; i < 4; i++) begin
      convert(vin[i], r, bc, dc, dp);
      checks++;
      if (r !== vexp[i] || dc !== 1 || dp !== 16) begin
        errors++;
        $display("FAIL value_%0d: bcd=%h dones=%0d pos=%0d required %h 1 16",
                 vin[i], r, dc, dp, vexp[i]);
      end
    end
  endtask

  // 1000/7 = 142; previous result (0x00010) must hold until completion.
  task automatic test_chain();
    int held_bad = 0; int dp = -1;
    din = 16'd142; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (j < 16 && bcd !== 20'h00010) held_bad++;
      if (done && dp < 0) dp = j;
      if (j == 16) begin
        checks++;
        if (bcd !== 20'h00142) begin errors++; $display("FAIL chain_bcd: got %h required 00142", bcd); end
      end
      @(negedge clk);
    end
    checks++;
    if (held_bad != 0) begin errors++; $display("FAIL chain_hold: %0d cycles changed, required 0", held_bad); end
    checks++;
    if (dp != 16) begin errors++; $display("FAIL chain_done_pos: got %0d required 16", dp); end
  endtask

  task automatic test_ignore_start();
    int dc = 0; int dp = -1; logic [19:0] r = 20'hxxxxx;
    din = 16'd4096; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (j == 4) begin start = 1'b1; din = 16'd999; end
      if (j == 5) start = 1'b0;
      if (done) begin dc++; if (dp < 0) dp = j; r = bcd; end
      @(negedge clk);
    end
    checks++;
    if (r !== 20'h04096) begin errors++; $display("FAIL ignore_bcd: got %h required 04096", r); end
    checks++;
    if (dc != 1 || dp != 16) begin
      errors++; $display("FAIL ignore_done: count=%0d pos=%0d required 1 at 16", dc, dp);
    end
  endtask

  task automatic test_async_reset();
    int dc = 0; int dp = -1; int bc = 0; logic [19:0] r = 20'hxxxxx;
    din = 16'd777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h00000) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b bcd=%h required 0 0 00000", busy, done, bcd);
    end
    @(negedge clk);
    din = 16'd300; start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 30; j++) begin
      if (busy) bc++;
      if (done) begin dc++; if (dp < 0) dp = j; r = bcd; end
      @(negedge clk);
    end
    checks++;
    if (r !== 20'h00300 || dc != 1 || dp != 16 || bc != 16) begin
      errors++;
      $display("FAIL after_reset_300: bcd=%h dones=%0d pos=%0d busy=%0d required 00300 1 16 16",
               r, dc, dp, bc);
    end
  endtask

  task automatic test_back_to_back();
    int dpos [$]; int bad_bcd = 0; int bad_gap = 0;
    din = 16'd50000; start = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 60; j++) begin
      if (done) begin
        dpos.push_back(j);
        if (bcd !== 20'h50000) bad_bcd++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (dpos.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d required 3", dpos.size());
    end else begin
      if (dpos[0] != 16) bad_gap++;
      for (int i = 1; i < 3; i++) if (dpos[i] - dpos[i-1] != 17) bad_gap++;
    end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL b2b_period: %0d bad intervals required 0", bad_gap); end
    checks++;
    if (bad_bcd != 0) begin errors++; $display("FAIL b2b_bcd: %0d wrong results required 0", bad_bcd); end
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_chain();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
